// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, controller state type and illegal-op check
// for the time-shared ALU controller.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd9;

  typedef enum logic {
    S_IDLE,
    S_EXEC
  } state_t;

  function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
    return (op > ALU_NOR);
  endfunction

endpackage

// File: rtl/ALU32Bit.sv
// Combinational 32-bit ALU; opcodes outside the defined set produce zero
// so nothing undefined can reach the result register.
module ALU32Bit
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] ALUControl,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  input  logic [4:0]          Shamt,
  output logic [31:0]         ALUResult
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_AND: ALUResult = A & B;
      ALU_OR:  ALUResult = A | B;
      ALU_ADD: ALUResult = A + B;
      ALU_XOR: ALUResult = A ^ B;
      ALU_SLL: ALUResult = B << Shamt;
      ALU_SRL: ALUResult = B >> Shamt;
      ALU_SUB: ALUResult = A - B;
      ALU_SLT: ALUResult = {31'b0, ($signed(A) < $signed(B))};
      ALU_MUL: ALUResult = $signed(A) * $signed(B);
      ALU_NOR: ALUResult = ~(A | B);
      default: ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: first asserted request at or after ptr_i,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [2:0]   idx_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          found;
  int unsigned   s;
  logic [IW-1:0] si;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s     = 0;
    si    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      s = 32'(ptr_i) + k;
      if (s >= N) s = s - N;
      si = IW'(s);
      if (!found && req_i[si]) begin
        found     = 1'b1;
        gnt_o[si] = 1'b1;
        idx_o     = 3'(s);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller time-sharing one ALU32Bit among NUM_REQ requesters;
// results return as a one-cycle tagged pulse.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [32*NUM_REQ-1:0]     req_a,
  input  logic [32*NUM_REQ-1:0]     req_b,
  input  logic [5*NUM_REQ-1:0]      req_shamt,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [2:0]                resp_id,
  output logic [31:0]               resp_data,
  output logic                      resp_err,
  output logic                      busy
);

  state_t                state_q;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [ALU_OP_W-1:0]   op_q;
  logic [31:0]           a_q, b_q;
  logic [4:0]            shamt_q;
  logic [2:0]            id_q;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [2:0]            resp_id_q;
  logic [31:0]           resp_data_q;
  logic                  resp_err_q;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [2:0]            pick_idx;
  logic                  window, accept, finish;
  logic [ALU_OP_W-1:0]   sel_op;
  logic [31:0]           sel_a, sel_b;
  logic [4:0]            sel_shamt;
  logic [31:0]           alu_res;
  logic [NUM_REQ-1:0]    id_onehot;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  ALU32Bit u_alu (
    .ALUControl (op_q),
    .A          (a_q),
    .B          (b_q),
    .Shamt      (shamt_q),
    .ALUResult  (alu_res)
  );

  // cnt_q is only nonzero while a MUL is still occupying the ALU
  assign window    = (state_q == S_IDLE) || (cnt_q == '0);
  assign finish    = (state_q == S_EXEC) && (cnt_q == '0);
  assign req_ready = window ? pick_gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_shamt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_op    = req_op[4*i +: 4];
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
        sel_shamt = req_shamt[5*i +: 5];
      end
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      id_onehot[i] = (id_q == 3'(i));
    end
  end

  assign rr_ptr_d = (pick_idx == 3'(NUM_REQ - 1)) ? '0 : pick_idx + 3'd1;
  assign cnt_d    = (sel_op == ALU_MUL) ? 3'(MUL_LAT - 1) : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      shamt_q      <= '0;
      id_q         <= '0;
      resp_valid_q <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (finish) begin
        resp_valid_q <= id_onehot;
        resp_id_q    <= id_q;
        resp_data_q  <= op_illegal(op_q) ? '0 : alu_res;
        resp_err_q   <= op_illegal(op_q);
      end
      if (state_q == S_EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (accept) begin
        op_q     <= sel_op;
        a_q      <= sel_a;
        b_q      <= sel_b;
        shamt_q  <= sel_shamt;
        id_q     <= pick_idx;
        rr_ptr_q <= rr_ptr_d;
        cnt_q    <= cnt_d;
        state_q  <= S_EXEC;
      end else if (finish) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q == S_EXEC);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with hand-computed expectations.
module tb_alu_share_ctrl;

  logic         Clk;
  logic         Reset;
  logic [3:0]   req_valid;
  logic [15:0]  req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [19:0]  req_shamt;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [2:0]   resp_id;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  alu_share_ctrl #(.NUM_REQ(4), .MUL_LAT(3)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_shamt  (req_shamt),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
    req_op[4*i +: 4]     = op;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
    req_shamt[5*i +: 5]  = sh;
    req_valid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    do_reset();
    checks++;
    if (resp_valid !== 4'b0000 || resp_id !== 3'd0 || resp_data !== 32'd0 ||
        resp_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rv=%b id=%0d data=%h err=%b busy=%b exp all zero",
               resp_valid, resp_id, resp_data, resp_err, busy);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL idle_no_req_ready got=%b exp=0000", req_ready);
    end
  endtask

  task automatic test_single_add();
    set_req(0, 4'd2, 32'd7, 32'd5, 5'd0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL add_ready got=%b exp=0001", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL add_busy got busy=%b rv=%b exp busy=1 rv=0000", busy, resp_valid);
    end
    step();
    checks++;
    if (resp_valid !== 4'b0001 || resp_id !== 3'd0 || resp_data !== 32'd12 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL add_resp got rv=%b id=%0d data=%h err=%b exp rv=0001 id=0 data=0000000c err=0",
               resp_valid, resp_id, resp_data, resp_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL add_idle got busy=%b exp=0", busy);
    end
    step();
    checks++;
    if (resp_valid !== 4'b0000 || resp_data !== 32'd12) begin
      failures++;
      $display("FAIL add_hold got rv=%b data=%h exp rv=0000 data=0000000c", resp_valid, resp_data);
    end
  endtask

  task automatic test_mul_latency();
    set_req(2, 4'd8, 32'hFFFF_FFFD, 32'd4, 5'd0);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL mul_ready got=%b exp=0100", req_ready);
    end
    step();
    req_valid = '0;
    set_req(0, 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mul_block1 got ready=%b busy=%b exp ready=0000 busy=1", req_ready, busy);
    end
    step();
    checks++;
    if (req_ready !== 4'b0000 || resp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mul_block2 got ready=%b rv=%b exp 0000 0000", req_ready, resp_valid);
    end
    step();
    checks++;
    if (req_ready !== 4'b0001 || resp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mul_window got ready=%b rv=%b exp ready=0001 rv=0000", req_ready, resp_valid);
    end
    step();
    req_valid = '0;
    checks++;
    if (resp_valid !== 4'b0100 || resp_id !== 3'd2 || resp_data !== 32'hFFFF_FFF4) begin
      failures++;
      $display("FAIL mul_resp got rv=%b id=%0d data=%h exp rv=0100 id=2 data=fffffff4",
               resp_valid, resp_id, resp_data);
    end
    step();
    checks++;
    if (resp_valid !== 4'b0001 || resp_id !== 3'd0 || resp_data !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL after_mul_or got rv=%b id=%0d data=%h exp rv=0001 id=0 data=000000ff",
               resp_valid, resp_id, resp_data);
    end
  endtask

  task automatic test_illegal();
    set_req(1, 4'd12, 32'h1234_5678, 32'h1111_1111, 5'd3);
    step();
    req_valid = '0;
    step();
    checks++;
    if (resp_valid !== 4'b0010 || resp_id !== 3'd1 || resp_data !== 32'd0 || resp_err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_resp got rv=%b id=%0d data=%h err=%b exp rv=0010 id=1 data=0 err=1",
               resp_valid, resp_id, resp_data, resp_err);
    end
  endtask

  task automatic test_back_to_back();
    set_req(3, 4'd6, 32'd1, 32'd2, 5'd0);
    step();
    set_req(3, 4'd7, 32'hFFFF_FFFF, 32'd0, 5'd0);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_ready got=%b exp=1000", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (resp_valid !== 4'b1000 || resp_data !== 32'hFFFF_FFFF || resp_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sub got rv=%b data=%h err=%b busy=%b exp rv=1000 data=ffffffff err=0 busy=1",
               resp_valid, resp_data, resp_err, busy);
    end
    step();
    checks++;
    if (resp_valid !== 4'b1000 || resp_id !== 3'd3 || resp_data !== 32'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_slt got rv=%b id=%0d data=%h busy=%b exp rv=1000 id=3 data=1 busy=0",
               resp_valid, resp_id, resp_data, busy);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  t_op  [7];
    logic [31:0] t_a   [7];
    logic [31:0] t_b   [7];
    logic [4:0]  t_sh  [7];
    logic [31:0] t_exp [7];
    t_op[0] = 4'd0; t_a[0] = 32'h0000_F0F0; t_b[0] = 32'h0000_FF00; t_sh[0] = 5'd0;  t_exp[0] = 32'h0000_F000;
    t_op[1] = 4'd3; t_a[1] = 32'h0000_FF00; t_b[1] = 32'h0000_0FF0; t_sh[1] = 5'd0;  t_exp[1] = 32'h0000_F0F0;
    t_op[2] = 4'd4; t_a[2] = 32'h0000_DEAD; t_b[2] = 32'h0000_0001; t_sh[2] = 5'd4;  t_exp[2] = 32'h0000_0010;
    t_op[3] = 4'd5; t_a[3] = 32'h0000_0000; t_b[3] = 32'h8000_0000; t_sh[3] = 5'd31; t_exp[3] = 32'h0000_0001;
    t_op[4] = 4'd9; t_a[4] = 32'hF0F0_F0F0; t_b[4] = 32'h0F0F_0000; t_sh[4] = 5'd0;  t_exp[4] = 32'h0000_0F0F;
    t_op[5] = 4'd2; t_a[5] = 32'hFFFF_FFFF; t_b[5] = 32'h0000_0002; t_sh[5] = 5'd0;  t_exp[5] = 32'h0000_0001;
    t_op[6] = 4'd7; t_a[6] = 32'h0000_0001; t_b[6] = 32'hFFFF_FFFF; t_sh[6] = 5'd0;  t_exp[6] = 32'h0000_0000;
    for (int i = 0; i < 7; i++) begin
      set_req(1, t_op[i], t_a[i], t_b[i], t_sh[i]);
      step();
      req_valid = '0;
      step();
      checks++;
      if (resp_valid !== 4'b0010 || resp_data !== t_exp[i] || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL op_%0d got rv=%b data=%h err=%b exp rv=0010 data=%h err=0",
                 t_op[i], resp_valid, resp_data, resp_err, t_exp[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    logic [3:0] exp_rv;
    int         g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'd2, 32'(100 + i), 32'(i), 5'd0);
    #1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      if (j == 5) req_valid = '0;
      if (j <= 4) begin
        exp_rdy = 4'b0001 << (j % 4);
        checks++;
        if (req_ready !== exp_rdy) begin
          failures++;
          $display("FAIL fair_grant_%0d got=%b exp=%b", j, req_ready, exp_rdy);
        end
      end
      if (j >= 2 && j <= 6) begin
        g      = (j - 2) % 4;
        exp_rv = 4'b0001 << g;
        checks++;
        if (resp_valid !== exp_rv || resp_id !== 3'(g) || resp_data !== 32'(100 + 2 * g)) begin
          failures++;
          $display("FAIL fair_resp_%0d got rv=%b id=%0d data=%0d exp rv=%b id=%0d data=%0d",
                   j, resp_valid, resp_id, resp_data, exp_rv, g, 100 + 2 * g);
        end
      end
      if (j == 7) begin
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
          failures++;
          $display("FAIL fair_drain got rv=%b busy=%b exp rv=0000 busy=0", resp_valid, busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    set_req(2, 4'd8, 32'd6, 32'd7, 5'd0);
    step();
    req_valid = '0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 4'b0000 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL midmul_abort got busy=%b rv=%b data=%h exp busy=0 rv=0000 data=0",
               busy, resp_valid, resp_data);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (resp_valid !== 4'b0000) begin
        failures++;
        $display("FAIL midmul_noresp_%0d got rv=%b exp=0000", k, resp_valid);
      end
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midmul_ptr got=%b exp=0001", req_ready);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    req_valid = '0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_vs_accept got busy=%b exp=0", busy);
    end
    step();
    checks++;
    if (resp_valid !== 4'b0000) begin
      failures++;
      $display("FAIL reset_vs_accept_resp got rv=%b exp=0000", resp_valid);
    end
  endtask

  initial begin
    Reset = 1'b1;
    test_reset();
    test_single_add();
    test_mul_latency();
    test_illegal();
    test_back_to_back();
    test_ops();
    test_fairness();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
